// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory byte-stream loader.
package imem_loader_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_t;

  // Framing states that still consume bytes from the receiver.
  function automatic logic is_receiving(input state_t s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input handshake plus instruction-memory write port of the loader.
interface imem_loader_if
  import imem_loader_pkg::*;
;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              write;
  logic [WORD_W-1:0] addr_in;
  logic [WORD_W-1:0] data;

  // master: byte source and memory sink; slave: the loader itself
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, write, addr_in, data
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, write, addr_in, data
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Collects four little-endian bytes into a word; word_valid pulses on the 4th byte.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              shift,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0]               cnt;
  logic [WORD_W-BYTE_W-1:0] shreg;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (shift) begin
      cnt   <= cnt + 2'd1;
      shreg <= {byte_in, shreg[WORD_W-BYTE_W-1:BYTE_W]};
    end
  end

  // The 4th byte is not stored; it is combined directly into the outgoing word.
  assign word_valid = shift && (cnt == 2'd3);
  assign word       = {byte_in, shreg};

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: length, LE words, XOR checksum -> instruction memory writes.
//
// state    | meaning
// ST_LEN0  | waiting for count[7:0]
// ST_LEN1  | waiting for count[15:8], range check
// ST_DATA  | receiving instruction bytes, one write per 4 bytes
// ST_CSUM  | waiting for checksum byte
// ST_DONE  | image verified, core released (sticky)
// ST_ERROR | frame rejected, core held (sticky)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         error,
  output logic [15:0]  words_loaded
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  state_t            state, state_next;
  logic              rx_ready;
  logic              accept;
  logic [BYTE_W-1:0] count_lo;
  logic [15:0]       count;
  logic [15:0]       len_full;
  logic [BYTE_W-1:0] csum;
  logic              word_valid;
  logic [WORD_W-1:0] word;
  logic              last_word;

  assign rx_ready     = reset_n && !start && is_receiving(state);
  assign bus.rx_ready = rx_ready;
  assign accept       = bus.rx_valid && rx_ready;
  assign len_full     = {bus.rx_data, count_lo};
  assign last_word    = (words_loaded + 16'd1) == count;

  imem_loader_byte_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (start),
    .shift      (accept && (state == ST_DATA)),
    .byte_in    (bus.rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_LEN0;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_LEN0: if (accept) state_next = ST_LEN1;
      ST_LEN1: begin
        if (accept) begin
          if (len_full == 16'd0)     state_next = ST_CSUM;
          else if (len_full > DEPTH_W) state_next = ST_ERROR;
          else                       state_next = ST_DATA;
        end
      end
      ST_DATA: if (word_valid && last_word) state_next = ST_CSUM;
      ST_CSUM: if (accept) state_next = (bus.rx_data == csum) ? ST_DONE : ST_ERROR;
      ST_DONE:  state_next = ST_DONE;
      ST_ERROR: state_next = ST_ERROR;
      default:  state_next = ST_LEN0;
    endcase
    if (start) state_next = ST_LEN0;
  end

  // addr_in/data keep the last written word; start only clears the bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.write    <= 1'b0;
      bus.addr_in  <= '0;
      bus.data     <= '0;
      words_loaded <= '0;
      csum         <= '0;
      count_lo     <= '0;
      count        <= '0;
    end else if (start) begin
      bus.write    <= 1'b0;
      words_loaded <= '0;
      csum         <= '0;
      count_lo     <= '0;
      count        <= '0;
    end else begin
      bus.write <= word_valid;
      if (word_valid) begin
        bus.addr_in  <= WORD_W'(words_loaded);
        bus.data     <= word;
        words_loaded <= words_loaded + 16'd1;
      end
      if (accept) csum <= csum ^ bus.rx_data;
      if (accept && (state == ST_LEN0)) count_lo <= bus.rx_data;
      if (accept && (state == ST_LEN1)) count <= len_full;
    end
  end

  assign done     = (state == ST_DONE);
  assign error    = (state == ST_ERROR);
  assign cpu_hold = (state != ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame-level reference model plus directed and random frames.
module tb_imem_loader;

  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        cpu_hold, done, error;
  logic [15:0] words_loaded;

  imem_loader_if bus();

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: the bytes accepted since the last start/reset fully determine every output.
  logic [7:0]  hist[$];
  logic        wr_exp = 1'b0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_data = '0;
  logic [63:0] wlog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int frame_count();
    if (hist.size() < 2) return 0;
    return int'({hist[1], hist[0]});
  endfunction

  // 0 = still loading, 1 = verified, 2 = rejected
  function automatic int frame_status();
    int n, cnt, need;
    logic [7:0] x;
    n = hist.size();
    if (n < 2) return 0;
    cnt = frame_count();
    if (cnt > DEPTH) return 2;
    need = 2 + 4 * cnt + 1;
    if (n < need) return 0;
    x = 8'h00;
    for (int k = 0; k < need - 1; k++) x ^= hist[k];
    return (hist[need-1] == x) ? 1 : 2;
  endfunction

  function automatic int exp_words();
    int n, w;
    n = hist.size();
    if (n <= 2) return 0;
    w = (n - 2) / 4;
    return (w > frame_count()) ? frame_count() : w;
  endfunction

  task automatic model_edge();
    int i;
    wr_exp = 1'b0;
    if (!reset_n) begin
      hist.delete();
      last_addr = '0;
      last_data = '0;
    end else if (start) begin
      hist.delete();
    end else if (bus.rx_valid && frame_status() == 0) begin
      hist.push_back(bus.rx_data);
      i = hist.size() - 1;
      if (i >= 2 && (i - 2) < 4 * frame_count() && ((i - 2) % 4) == 3) begin
        wr_exp    = 1'b1;
        last_addr = 32'((i - 2) / 4);
        last_data = {hist[i], hist[i-1], hist[i-2], hist[i-3]};
      end
    end
  endtask

  task automatic model_check();
    int st;
    st = frame_status();
    chk("rx_ready", 32'(bus.rx_ready), 32'(reset_n && !start && st == 0));
    chk("write", 32'(bus.write), 32'(wr_exp));
    chk("addr_in", bus.addr_in, last_addr);
    chk("data", bus.data, last_data);
    chk("done", 32'(done), 32'(st == 1));
    chk("error", 32'(error), 32'(st == 2));
    chk("cpu_hold", 32'(cpu_hold), 32'(st != 1));
    chk("words_loaded", 32'(words_loaded), 32'(exp_words()));
    if (bus.write === 1'b1) wlog.push_back({bus.addr_in, bus.data});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      model_check();
    end
  end

  // Drivers assume they are entered just after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int gap, k;
    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      if (bus.rx_ready === 1'b1) begin
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        break;
      end
      @(posedge clk); #1;
      k++;
      if (k > 40) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: byte %0h not accepted within 40 cycles", b);
        bus.rx_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] fr[$], input int nsend, input int maxgap);
    for (int k = 0; k < nsend; k++) send_byte(fr[k], maxgap);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic settle();
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
  endtask

  logic [7:0] f1[$];
  logic [7:0] fz[$];
  logic [7:0] fbig[$];
  logic [7:0] fbad[$];
  logic [7:0] fmax[$];
  logic [7:0] fr[$];

  initial begin
    int cnt, nsend, aborted, good;
    logic [7:0] x;

    f1   = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h27, 8'h00, 8'h00, 8'h81};
    fz   = '{8'h00, 8'h00, 8'h00};
    fbig = '{8'h81, 8'h00};
    fbad = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00};
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_write", 32'(bus.write), 32'd0);
    chk("rst_addr", bus.addr_in, 32'd0);
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    @(posedge clk); #1;

    // Reference frame, back-to-back bytes
    wlog.delete();
    send_frame(f1, f1.size(), 0);
    settle();
    chk("f1_nwrites", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("f1_w0", wlog[0][31:0], 32'h00000013);
      chk("f1_a0", wlog[0][63:32], 32'd0);
      chk("f1_w1", wlog[1][31:0], 32'h000027B7);
      chk("f1_a1", wlog[1][63:32], 32'd1);
    end
    chk("f1_done", 32'(done), 32'd1);
    chk("f1_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("f1_words", 32'(words_loaded), 32'd2);

    // Same frame with gaps
    pulse_start();
    wlog.delete();
    send_frame(f1, f1.size(), 3);
    settle();
    chk("f1gap_nwrites", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("f1gap_w0", wlog[0][31:0], 32'h00000013);
      chk("f1gap_w1", wlog[1][31:0], 32'h000027B7);
    end
    chk("f1gap_done", 32'(done), 32'd1);

    // Empty image
    pulse_start();
    wlog.delete();
    send_frame(fz, fz.size(), 0);
    settle();
    chk("empty_nwrites", 32'(wlog.size()), 32'd0);
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_words", 32'(words_loaded), 32'd0);

    // Count above depth
    pulse_start();
    wlog.delete();
    send_frame(fbig, fbig.size(), 0);
    settle();
    chk("big_error", 32'(error), 32'd1);
    chk("big_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("big_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("big_nwrites", 32'(wlog.size()), 32'd0);

    // Bad checksum
    pulse_start();
    wlog.delete();
    send_frame(fbad, fbad.size(), 0);
    settle();
    chk("badcs_nwrites", 32'(wlog.size()), 32'd1);
    if (wlog.size() == 1) begin
      chk("badcs_w0", wlog[0][31:0], 32'h00000013);
      chk("badcs_a0", wlog[0][63:32], 32'd0);
    end
    chk("badcs_error", 32'(error), 32'd1);
    chk("badcs_done", 32'(done), 32'd0);

    // Reset after 6th byte, then full reload
    pulse_start();
    send_frame(f1, 6, 0);
    pulse_reset();
    @(negedge clk);
    chk("mrst_words", 32'(words_loaded), 32'd0);
    chk("mrst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_data", bus.data, 32'd0);
    chk("mrst_addr", bus.addr_in, 32'd0);
    @(posedge clk); #1;
    wlog.delete();
    send_frame(f1, f1.size(), 0);
    settle();
    chk("reload_nwrites", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("reload_a0", wlog[0][63:32], 32'd0);
      chk("reload_a1", wlog[1][63:32], 32'd1);
    end
    chk("reload_done", 32'(done), 32'd1);

    // Start while done
    pulse_start();
    @(negedge clk);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("restart_rx_ready", 32'(bus.rx_ready), 32'd1);
    @(posedge clk); #1;

    // Full-depth image
    fmax.delete();
    fmax.push_back(8'(DEPTH));
    fmax.push_back(8'(DEPTH >> 8));
    for (int k = 0; k < 4 * DEPTH; k++) fmax.push_back(8'($urandom_range(255, 0)));
    x = 8'h00;
    foreach (fmax[k]) x ^= fmax[k];
    fmax.push_back(x);
    wlog.delete();
    send_frame(fmax, fmax.size(), 0);
    settle();
    chk("max_nwrites", 32'(wlog.size()), 32'(DEPTH));
    if (wlog.size() == DEPTH) chk("max_last_addr", wlog[DEPTH-1][63:32], 32'(DEPTH - 1));
    chk("max_done", 32'(done), 32'd1);

    // Random frames: sizes, gaps, corrupt checksums, aborts
    for (int r = 0; r < 40; r++) begin
      pulse_start();
      wlog.delete();
      fr.delete();
      cnt = ($urandom_range(7, 0) == 0) ? 129 + int'($urandom_range(100, 0))
                                        : int'($urandom_range(5, 0));
      fr.push_back(8'(cnt));
      fr.push_back(8'(cnt >> 8));
      if (cnt <= DEPTH)
        for (int k = 0; k < 4 * cnt; k++) fr.push_back(8'($urandom_range(255, 0)));
      x = 8'h00;
      foreach (fr[k]) x ^= fr[k];
      good = ($urandom_range(3, 0) != 0) ? 1 : 0;
      if (!good) x ^= 8'(1 << $urandom_range(7, 0));
      if (cnt <= DEPTH) fr.push_back(x);
      aborted = ($urandom_range(7, 0) == 0) ? 1 : 0;
      nsend = aborted ? int'($urandom_range(fr.size() - 1, 1)) : fr.size();
      send_frame(fr, nsend, int'($urandom_range(2, 0)));
      settle();
      if (!aborted) begin
        chk("rand_nwrites", 32'(wlog.size()), 32'((cnt <= DEPTH) ? cnt : 0));
        chk("rand_done", 32'(done), 32'(cnt <= DEPTH && good == 1));
        chk("rand_error", 32'(error), 32'(cnt > DEPTH || good == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that fills the instruction memory through its write port (`write`, `addr_in`, `data`) before the core runs. It receives a framed byte stream (length, little-endian instruction words, checksum) over a valid/ready handshake and assembles 32-bit words. It issues one single-cycle write per word at consecutive word indices and holds the core in reset until a verified image is loaded. It sits between a serial receiver (e.g. UART RX) and the instruction memory's write side.

## Interface
- `DEPTH`, 128: instruction memory depth in words; the maximum accepted word count.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `start` input 1: single-cycle pulse that aborts the current load and restarts framing.
- `rx_data` input 8: incoming byte.
- `rx_valid` input 1: `rx_data` is valid.
- `rx_ready` output 1: loader accepts a byte this cycle.
- `write` output 1: instruction memory write strobe.
- `addr_in` output 32: word index to write; memory indexes words directly, not byte address.
- `data` output 32: assembled instruction word.
- `cpu_hold` output 1: keeps the core in reset while high.
- `done` output 1: image loaded and checksum verified.
- `error` output 1: frame rejected.
- `words_loaded` output 16: number of words written so far.

## Operation
- Frame layout:
  - LEN0: count[7:0].
  - LEN1: count[15:8].
  - 4×count data bytes, little-endian per word (first byte → bits [7:0]).
  - CSUM: one checksum byte.
- Checksum: XOR of every preceding frame byte, including the length bytes. CSUM must equal this value.
- A byte is accepted on a rising edge with `rx_valid & rx_ready`. Nothing else advances state.
- States and transitions:
  - LEN0 → LEN1 on an accepted byte.
  - LEN1 → DATA if 1 ≤ count ≤ DEPTH.
  - LEN1 → CSUM if count == 0.
  - LEN1 → ERROR if count > DEPTH. No write occurs.
  - DATA: a 2-bit byte counter wraps 3→0. On each 4th byte the word is written. After the last word → CSUM.
  - CSUM → DONE on a matching byte; → ERROR on a mismatch.
  - DONE and ERROR are sticky until `start` or reset.
- `rx_ready` = 1 in LEN0, LEN1, DATA and CSUM; 0 in DONE and ERROR.
- Word index starts at 0, increments after each write, and never exceeds DEPTH-1.
- `words_loaded` increments with each write and is cleared by `start` or reset.
- `start`, in any state, clears the byte counter, word index, checksum and `words_loaded`. It deasserts `done` and `error`, asserts `cpu_hold` and enters LEN0. In the start cycle `rx_valid` is ignored.
- Reset values:
  - state LEN0.
  - `write`, `addr_in`, `data`, `words_loaded`, `done`, `error` all 0.
  - `cpu_hold` 1.
  - `rx_ready` 0 while `reset_n` is low.
- Reset mid-load abandons the frame. Words already written stay in memory; the next frame overwrites from index 0.

## Timing
- `write`, `addr_in` and `data` are registered.
- `write` is high for exactly one cycle: the cycle after the edge that accepted the 4th byte of a word. `addr_in` and `data` are valid in that same cycle.
- `addr_in` and `data` hold their values after `write` falls.
- The loader accepts a byte every cycle, including during a `write` pulse. Sustained throughput is 1 byte/clk.
- `done` rises and `cpu_hold` falls in the cycle after the CSUM byte is accepted. The last `write` always precedes `done` by at least one cycle.
- `error` rises the cycle after the rejecting byte is accepted. `cpu_hold` stays 1 in ERROR.
- Gaps on `rx_valid` stall all counters; there is no timeout.

## Structure
- Shared package holds:
  - state encoding: LEN0, LEN1, DATA, CSUM, DONE, ERROR.
  - the word-width constant (32).
  - the byte-width constant (8).
- Single module. An optional sub-module `byte_packer` holds the 4-byte shift/assembly register and its 2-bit counter, and emits a `word_valid` pulse.

## Test plan
- Frame 02 00 13 00 00 00 B7 27 00 00 81, `rx_valid` continuous:
  - write at addr 0 with data 0x00000013.
  - write at addr 1 with data 0x000027B7.
  - `done`=1, `cpu_hold`=0, `words_loaded`=2.
- Same frame with random 0–3 cycle `rx_valid` gaps → identical writes and `done`; no extra `write` pulses.
- Frame 00 00 00 → no write, `done`=1, `words_loaded`=0.
- Frame 81 00 (count 129 > DEPTH):
  - `error`=1 and `rx_ready`=0.
  - no write, `cpu_hold`=1.
- Frame 01 00 13 00 00 00 00 (checksum should be 0x12):
  - one write, addr 0, data 0x00000013.
  - then `error`=1, `done`=0.
- `reset_n` low for one cycle after the 6th byte of the first frame:
  - all outputs return to reset values.
  - resending the full first frame reproduces writes at addr 0 and 1, then `done`.
  - `start` in DONE → `done`=0, `cpu_hold`=1, `rx_ready`=1 the next cycle.
